// File: rtl/cpu_branch_ctrl.sv
// ----------------------------------------------------------------------------
// cpu_branch_ctrl
//   Control-flow stage that sits directly upstream of the program counter.
//   It decodes jump, branch, call and return requests and drives the PC's
//   load strobe and load address combinationally, so the PC takes the new
//   value on the next clock edge. A hardware return-address stack (RAS)
//   holds the return addresses for CALL/RET.
//
// Parameters
//   WIDTH : address width (matches the PC width)
//   DEPTH : number of RAS entries (>= 2)
//
// Ports
//   CLK    in   clock, rising edge
//   RST_N  in   asynchronous active-low reset
//   EN     in   instruction valid / not stalled; 0 = no action
//   PC     in   current PC value
//   TARGET in   jump / call target
//   JMP    in   unconditional jump
//   JZ     in   jump if ZF = 1
//   JNZ    in   jump if ZF = 0
//   CALL   in   push PC+1 and jump to TARGET
//   RET    in   pop and jump to the popped address
//   ZF     in   ALU zero flag
//   LD     out  PC load strobe
//   ADDR   out  PC load address
//   SP     out  stack occupancy, 0..DEPTH
//   FULL   out  SP == DEPTH
//   EMPTY  out  SP == 0
//   ERR    out  sticky overflow / underflow flag
// ----------------------------------------------------------------------------
module cpu_branch_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int SPW  = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [WIDTH-1:0] PC,
  input  logic [WIDTH-1:0] TARGET,
  input  logic             JMP,
  input  logic             JZ,
  input  logic             JNZ,
  input  logic             CALL,
  input  logic             RET,
  input  logic             ZF,
  output logic             LD,
  output logic [WIDTH-1:0] ADDR,
  output logic [SPW-1:0]   SP,
  output logic             FULL,
  output logic             EMPTY,
  output logic             ERR
);

  localparam int IDXW = $clog2(DEPTH);

  logic [SPW-1:0]   sp_q, sp_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] ras_q [DEPTH];

  logic             full, empty;
  logic             push, pop;
  logic [IDXW-1:0]  push_idx, top_idx;
  logic [WIDTH-1:0] ret_addr;

  // Flags come only from the registered pointer, never from the requests.
  assign full  = (sp_q == SPW'(DEPTH));
  assign empty = (sp_q == '0);

  // Push slot is the current SP; top of stack sits one below it. Both are
  // only used when they are in range (not full / not empty respectively).
  assign push_idx = IDXW'(sp_q);
  assign top_idx  = IDXW'(sp_q - SPW'(1));
  assign ret_addr = ras_q[top_idx];

  // Request decode with priority RET > CALL > JMP > JZ > JNZ. Gating on
  // RST_N keeps LD/ADDR low for the whole time reset is held.
  always_comb begin
    LD    = 1'b0;
    ADDR  = '0;
    push  = 1'b0;
    pop   = 1'b0;
    err_d = err_q;
    if (RST_N && EN) begin
      if (RET) begin
        if (!empty) begin
          LD   = 1'b1;
          ADDR = ret_addr;
          pop  = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else if (CALL) begin
        // On overflow LD stays low so the PC simply increments.
        if (!full) begin
          LD   = 1'b1;
          ADDR = TARGET;
          push = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else if (JMP) begin
        LD   = 1'b1;
        ADDR = TARGET;
      end else if (JZ) begin
        if (ZF) begin
          LD   = 1'b1;
          ADDR = TARGET;
        end
      end else if (JNZ) begin
        if (!ZF) begin
          LD   = 1'b1;
          ADDR = TARGET;
        end
      end
    end
  end

  always_comb begin
    sp_d = sp_q;
    if (push)     sp_d = sp_q + SPW'(1);
    else if (pop) sp_d = sp_q - SPW'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sp_q  <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ras_q[i] <= '0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
      // Return address wraps modulo 2^WIDTH; a popped entry is left in place.
      if (push) ras_q[push_idx] <= PC + WIDTH'(1);
    end
  end

  assign SP    = sp_q;
  assign FULL  = full;
  assign EMPTY = empty;
  assign ERR   = err_q;

endmodule

// File: tb/tb_cpu_branch_ctrl.sv
module tb_cpu_branch_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int SPW   = $clog2(DEPTH + 1);

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             EN;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] TARGET;
  logic             JMP, JZ, JNZ, CALL, RET, ZF;
  logic             LD;
  logic [WIDTH-1:0] ADDR;
  logic [SPW-1:0]   SP;
  logic             FULL, EMPTY, ERR;

  int n_chk  = 0;
  int n_fail = 0;

  cpu_branch_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .PC(PC), .TARGET(TARGET),
    .JMP(JMP), .JZ(JZ), .JNZ(JNZ), .CALL(CALL), .RET(RET), .ZF(ZF),
    .LD(LD), .ADDR(ADDR), .SP(SP), .FULL(FULL), .EMPTY(EMPTY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    EN = 1'b1; JMP = 0; JZ = 0; JNZ = 0; CALL = 0; RET = 0; ZF = 0;
    PC = '0; TARGET = '0;
  endtask

  // Advance through one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_call(input logic [7:0] pc, input logic [7:0] tgt);
    idle(); CALL = 1; PC = pc; TARGET = tgt;
    #1;
  endtask

  task automatic do_ret();
    idle(); RET = 1;
    #1;
  endtask

  initial begin
    idle();
    RST_N = 1'b0;
    #12 RST_N = 1'b1;
    step();

    // ---- 1. asynchronous reset mid-cycle ----
    do_call(8'h03, 8'h33);
    step();
    chk("pre_reset_sp", SP, 1);
    idle(); JMP = 1; TARGET = 8'h40;
    #1;
    chk("pre_reset_ld", LD, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_ld", LD, 0);
    chk("rst_addr", ADDR, 0);
    chk("rst_sp", SP, 0);
    chk("rst_empty", EMPTY, 1);
    chk("rst_err", ERR, 0);
    chk("rst_full", FULL, 0);
    idle();
    #2 RST_N = 1'b1;
    step();

    // ---- 2. jumps and conditional branches ----
    idle(); JMP = 1; TARGET = 8'h40; #1;
    chk("jmp_ld", LD, 1);
    chk("jmp_addr", ADDR, 8'h40);
    idle(); JZ = 1; ZF = 0; TARGET = 8'h55; #1;
    chk("jz_nt_ld", LD, 0);
    chk("jz_nt_addr", ADDR, 0);
    idle(); JZ = 1; ZF = 1; TARGET = 8'h55; #1;
    chk("jz_t_addr", ADDR, 8'h55);
    idle(); JNZ = 1; ZF = 0; TARGET = 8'h10; #1;
    chk("jnz_t_ld", LD, 1);
    chk("jnz_t_addr", ADDR, 8'h10);
    idle(); JNZ = 1; ZF = 1; TARGET = 8'h10; #1;
    chk("jnz_nt_ld", LD, 0);
    idle(); #1;
    chk("noreq_ld", LD, 0);
    step();
    chk("jumps_sp", SP, 0);

    // ---- 3. nested calls and returns ----
    do_call(8'h05, 8'h20);
    chk("call1_ld", LD, 1);
    chk("call1_addr", ADDR, 8'h20);
    step();
    chk("call1_sp", SP, 1);
    do_call(8'h21, 8'h30);
    chk("call2_addr", ADDR, 8'h30);
    step();
    chk("call2_sp", SP, 2);
    do_ret();
    chk("ret1_ld", LD, 1);
    chk("ret1_addr", ADDR, 8'h22);
    step();
    chk("ret1_sp", SP, 1);
    do_ret();
    chk("ret2_addr", ADDR, 8'h06);
    step();
    chk("ret2_sp", SP, 0);
    chk("ret2_empty", EMPTY, 1);
    do_call(8'h05, 8'h20); EN = 0; #1;
    chk("en0_call_ld", LD, 0);
    chk("en0_call_addr", ADDR, 0);
    step();
    chk("en0_call_sp", SP, 0);
    do_call(8'h05, 8'h20);
    step();
    do_ret(); EN = 0; #1;
    chk("en0_ret_ld", LD, 0);
    step();
    chk("en0_ret_sp", SP, 1);
    do_ret();
    step();
    chk("en0_err", ERR, 0);

    // ---- 4. overflow ----
    for (int i = 0; i < DEPTH; i++) begin
      do_call(8'(i), 8'(8'h80 + i));
      step();
    end
    chk("ovf_full", FULL, 1);
    chk("ovf_sp_pre", SP, DEPTH);
    chk("ovf_err_pre", ERR, 0);
    do_call(8'h70, 8'h90);
    chk("ovf_ld", LD, 0);
    chk("ovf_addr", ADDR, 0);
    step();
    chk("ovf_sp", SP, DEPTH);
    chk("ovf_err", ERR, 1);
    do_ret();
    chk("ovf_ret_addr", ADDR, 8'h08);
    step();
    chk("ovf_ret_sp", SP, DEPTH - 1);
    chk("ovf_err_sticky", ERR, 1);
    chk("ovf_full_clr", FULL, 0);

    idle();
    #3 RST_N = 1'b0;
    #2 RST_N = 1'b1;
    step();
    chk("rst2_err", ERR, 0);

    // ---- 5. underflow, priority, PC wrap ----
    do_ret();
    chk("udf_ld", LD, 0);
    chk("udf_addr", ADDR, 0);
    step();
    chk("udf_err", ERR, 1);
    chk("udf_sp", SP, 0);
    do_call(8'h10, 8'h50);
    step();
    chk("pri_sp_pre", SP, 1);
    idle(); RET = 1; CALL = 1; JMP = 1; PC = 8'h44; TARGET = 8'h99; #1;
    chk("pri_ld", LD, 1);
    chk("pri_addr", ADDR, 8'h11);
    step();
    chk("pri_sp", SP, 0);
    do_ret();
    chk("pri_nopush_ld", LD, 0);
    step();
    idle(); CALL = 1; JMP = 1; TARGET = 8'h66; PC = 8'h01; #1;
    chk("pri_call_jmp_addr", ADDR, 8'h66);
    step();
    chk("pri_call_jmp_sp", SP, 1);
    do_ret();
    chk("pri_call_jmp_ret", ADDR, 8'h02);
    step();
    do_call(8'hFF, 8'h12);
    step();
    do_ret();
    chk("wrap_ld", LD, 1);
    chk("wrap_addr", ADDR, 8'h00);
    step();
    chk("wrap_sp", SP, 0);
    chk("wrap_err_sticky", ERR, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
